// File: rtl/wisc_flags_pkg.sv
// Shared types for the WISC flag/branch path: opcodes, branch condition
// codes, the {Z,N,V} flag struct, the branch FSM state encoding and the
// opcode groups that decide which flags a retiring ALU op may write.
package wisc_flags_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111,
        OP_LW     = 4'b1000,
        OP_SW     = 4'b1001,
        OP_LHB    = 4'b1010,
        OP_LLB    = 4'b1011,
        OP_B      = 4'b1100,
        OP_BR     = 4'b1101,
        OP_PCS    = 4'b1110,
        OP_HLT    = 4'b1111
    } opcode_t;

    typedef enum logic [2:0] {
        BR_NEQ    = 3'b000,
        BR_EQ     = 3'b001,
        BR_GT     = 3'b010,
        BR_LT     = 3'b011,
        BR_GTE    = 3'b100,
        BR_LTE    = 3'b101,
        BR_OVFL   = 3'b110,
        BR_UNCOND = 3'b111
    } br_cond_t;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT    = 2'b01,
        ST_RESOLVE = 2'b10
    } br_state_t;

    // One bit per opcode: ADD/SUB write all three flags.
    localparam logic [15:0] NZV_OP_MASK    = 16'h0003;
    // XOR, SLL, SRA, ROR write Z only.
    localparam logic [15:0] Z_ONLY_OP_MASK = 16'h0074;

    function automatic logic op_writes_nzv(input logic [3:0] op);
        return NZV_OP_MASK[op];
    endfunction

    function automatic logic op_writes_z_only(input logic [3:0] op);
        return Z_ONLY_OP_MASK[op];
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a WISC branch condition code against a
// {Z,N,V} flag set.
module branch_cond_eval
    import wisc_flags_pkg::*;
(
    input  br_cond_t cond,
    input  flags_t   flags,
    output logic     taken
);

    // Decode the condition code into a taken/not-taken decision.
    always_comb begin
        taken = 1'b0;
        case (cond)
            BR_NEQ:    taken = ~flags.z;
            BR_EQ:     taken = flags.z;
            BR_GT:     taken = ~flags.z & ~flags.n;
            BR_LT:     taken = flags.n;
            BR_GTE:    taken = flags.z | (~flags.z & ~flags.n);
            BR_LTE:    taken = flags.n | flags.z;
            BR_OVFL:   taken = flags.v;
            BR_UNCOND: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: captures Z/N/V from retiring ALU ops, counts in-flight
// flag writers and resolves conditional branches once every older writer
// has retired.
// Optional feature macro: FLAG_BYPASS_EN -- when defined, the retirement
// that drains the last pending writer forwards its flags straight to the
// condition evaluator, so the branch resolves one cycle after that retire
// instead of going through the RESOLVE state.
module flag_branch_unit
    import wisc_flags_pkg::*;
#(
    parameter int MAX_INFLIGHT = 2,
    parameter int DW           = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_vld,
    output logic          iss_rdy,
    input  logic          ret_vld,
    input  logic [3:0]    ret_op,
    input  logic [DW-1:0] ret_result,
    input  logic          ret_ovfl,
    input  logic          br_req,
    input  logic [2:0]    br_cond,
    output logic          br_rdy,
    output logic          br_vld,
    output logic          br_taken,
    output logic [2:0]    flags
);

    localparam int            CW      = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    flags_t        flags_q, flags_d;
    logic [CW-1:0] pend_q, pend_d;
    br_state_t     state_q, state_d;
    br_cond_t      cond_q, cond_d;
    logic          byp_vld_q, byp_vld_d;
    logic          byp_taken_q, byp_taken_d;

    logic          iss_fire;
    logic          ret_counts;
    logic          bypass_hit;
    logic          eval_taken;
    flags_t        eval_flags;

    assign iss_rdy    = (pend_q < MAX_CNT);
    assign iss_fire   = iss_vld & iss_rdy;
    // A retire with nothing outstanding still updates flags but must not underflow.
    assign ret_counts = ret_vld & (pend_q != '0);
    assign flags      = flags_q;

    // Next flag value: the opcode group of the retiring op picks which flags move.
    always_comb begin
        flags_d = flags_q;
        if (ret_vld) begin
            if (op_writes_nzv(ret_op)) begin
                flags_d.z = (ret_result == '0);
                flags_d.n = ret_result[DW-1];
                flags_d.v = ret_ovfl;
            end else if (op_writes_z_only(ret_op)) begin
                flags_d.z = (ret_result == '0);
            end
        end
    end

    // Pending-writer count: simultaneous issue and retire cancel out.
    always_comb begin
        pend_d = pend_q;
        case ({iss_fire, ret_counts})
            2'b10:   pend_d = pend_q + 1'b1;
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase
    end

`ifdef FLAG_BYPASS_EN
    // While waiting, the evaluator looks at the incoming flags so the draining
    // retirement can be resolved in the same cycle; RESOLVE uses the register.
    assign eval_flags = (state_q == ST_WAIT) ? flags_d : flags_q;
    assign bypass_hit = (state_q == ST_WAIT) && (pend_q != '0) && (pend_d == '0);
`else
    assign eval_flags = flags_q;
    assign bypass_hit = 1'b0;
`endif

    branch_cond_eval u_cond_eval (
        .cond  (cond_q),
        .flags (eval_flags),
        .taken (eval_taken)
    );

    // Branch FSM next state: capture the condition, wait for writers to drain, resolve.
    always_comb begin
        state_d     = state_q;
        cond_d      = cond_q;
        byp_vld_d   = 1'b0;
        byp_taken_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (br_req) begin
                    cond_d = br_cond_t'(br_cond);
                    // An issue in this same cycle is younger than the branch and is not waited on.
                    if ((pend_q == '0) && !ret_vld) begin
                        state_d = ST_RESOLVE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (pend_q == '0) begin
                    state_d = ST_RESOLVE;
                end else if (bypass_hit) begin
                    state_d     = ST_IDLE;
                    byp_vld_d   = 1'b1;
                    byp_taken_d = eval_taken;
                end
            end
            ST_RESOLVE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Branch FSM outputs: RESOLVE pulses from registered flags, bypass pulses from its latch.
    always_comb begin
        br_rdy   = (state_q == ST_IDLE);
        br_vld   = (state_q == ST_RESOLVE) | byp_vld_q;
        br_taken = 1'b0;
        if (state_q == ST_RESOLVE) begin
            br_taken = eval_taken;
        end else if (byp_vld_q) begin
            br_taken = byp_taken_q;
        end
    end

    // State register for flags, pending count and the branch FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= '0;
            pend_q      <= '0;
            state_q     <= ST_IDLE;
            cond_q      <= BR_NEQ;
            byp_vld_q   <= 1'b0;
            byp_taken_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            pend_q      <= pend_d;
            state_q     <= state_d;
            cond_q      <= cond_d;
            byp_vld_q   <= byp_vld_d;
            byp_taken_q <= byp_taken_d;
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Randomized and directed bench for flag_branch_unit against a cycle-level
// behavioural model of the flag, pending-count and branch-timing rules.
module tb_flag_branch_unit;

`ifdef FLAG_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iss_vld = 1'b0;
    logic        iss_rdy;
    logic        ret_vld = 1'b0;
    logic [3:0]  ret_op = '0;
    logic [15:0] ret_result = '0;
    logic        ret_ovfl = 1'b0;
    logic        br_req = 1'b0;
    logic [2:0]  br_cond = '0;
    logic        br_rdy;
    logic        br_vld;
    logic        br_taken;
    logic [2:0]  flags;

    int checks = 0;
    int failures = 0;

    // model state
    logic [2:0] m_flags;
    int         m_pend;
    bit         m_active;
    bit         m_byp;
    int         m_due;
    logic [2:0] m_cond;
    int         cyc;
    int         last_vld_cyc;
    logic       last_taken;

    always #5 clk = ~clk;

    flag_branch_unit #(.MAX_INFLIGHT(2), .DW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_vld    (iss_vld),
        .iss_rdy    (iss_rdy),
        .ret_vld    (ret_vld),
        .ret_op     (ret_op),
        .ret_result (ret_result),
        .ret_ovfl   (ret_ovfl),
        .br_req     (br_req),
        .br_cond    (br_cond),
        .br_rdy     (br_rdy),
        .br_vld     (br_vld),
        .br_taken   (br_taken),
        .flags      (flags)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit cond_fn(input logic [2:0] c, input logic [2:0] f);
        bit z, n, v;
        z = f[2]; n = f[1]; v = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] new_flags(input logic [2:0] f, input logic [3:0] op,
                                             input logic [15:0] res, input logic ov);
        if (op == 4'd0 || op == 4'd1) return {res == 16'd0, res[15], ov};
        if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return {res == 16'd0, f[1], f[0]};
        return f;
    endfunction

    task automatic model_reset();
        m_flags = 3'b000; m_pend = 0; m_active = 0; m_byp = 0; m_due = -1; m_cond = 3'd0;
    endtask

    // One clock: drive, check at negedge against the model, advance the model.
    task automatic cycle(input logic iv, input logic rv, input logic [3:0] op, input logic [15:0] res,
                         input logic ov, input logic bq, input logic [2:0] bc);
        bit rdy_exp, vld_exp;
        int np;
        iss_vld = iv; ret_vld = rv; ret_op = op; ret_result = res; ret_ovfl = ov;
        br_req = bq; br_cond = bc;
        @(negedge clk);
        rdy_exp = !(m_active && !(cyc == m_due && m_byp));
        vld_exp = m_active && (cyc == m_due);
        chk("iss_rdy", iss_rdy, m_pend < 2);
        chk("flags", flags, m_flags);
        chk("br_rdy", br_rdy, rdy_exp);
        chk("br_vld", br_vld, vld_exp);
        if (br_vld) begin
            last_vld_cyc = cyc;
            last_taken = br_taken;
            if (vld_exp) chk("br_taken", br_taken, cond_fn(m_cond, m_flags));
        end
        np = m_pend + ((iv && m_pend < 2) ? 1 : 0) - ((rv && m_pend > 0) ? 1 : 0);
        if (vld_exp) m_active = 0;
        if (m_active && m_due < 0 && np == 0) begin
            m_due = cyc + (BYP ? 1 : 2);
            m_byp = (BYP != 0);
        end
        if (bq && rdy_exp) begin
            m_active = 1; m_cond = bc; m_byp = 0;
            if (m_pend == 0 && !rv) m_due = cyc + 1;
            else if (np == 0)        m_due = cyc + 2;
            else                     m_due = -1;
        end
        if (rv) m_flags = new_flags(m_flags, op, res, ov);
        m_pend = np;
        cyc++;
        @(posedge clk);
        #1;
        iss_vld = 0; ret_vld = 0; br_req = 0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 4'd0, 16'd0, 0, 0, 3'd0);
    endtask

    // Request a branch and wait (bounded) for its resolution.
    task automatic run_branch(input logic [2:0] c, output int lat, output logic tk);
        int rq;
        rq = cyc;
        last_vld_cyc = -1;
        cycle(0, 0, 4'd0, 16'd0, 0, 1, c);
        for (int i = 0; i < 10 && last_vld_cyc < 0; i++) idle(1);
        lat = (last_vld_cyc < 0) ? 999 : last_vld_cyc - rq;
        tk = last_taken;
    endtask

    task automatic async_reset_check();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_flags", flags, 3'b000);
        chk("rst_br_vld", br_vld, 1'b0);
        chk("rst_br_rdy", br_rdy, 1'b1);
        chk("rst_iss_rdy", iss_rdy, 1'b1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int rc;
        logic tk;
        bit iv, rv, bq;
        logic [15:0] res;
        cyc = 0; last_vld_cyc = -1; last_taken = 0;
        model_reset();
        #1;
        chk("por_flags", flags, 3'b000);
        chk("por_br_rdy", br_rdy, 1'b1);
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        idle(2);

        // ADD result 0 then EQ with nothing pending
        cycle(0, 1, 4'd0, 16'h0000, 0, 0, 3'd0);
        chk("t2_flags", flags, 3'b100);
        run_branch(3'd1, lat, tk);
        chk("t2_lat", lat, 1);
        chk("t2_taken", tk, 1'b1);

        // SUB 8000 with overflow, then OVFL and GT
        cycle(0, 1, 4'd1, 16'h8000, 1, 0, 3'd0);
        chk("t3_flags", flags, 3'b011);
        run_branch(3'd6, lat, tk);
        chk("t3_ovfl_taken", tk, 1'b1);
        run_branch(3'd2, lat, tk);
        chk("t3_gt_taken", tk, 1'b0);

        // branch waits on an older writer
        cycle(1, 0, 4'd0, 16'h0, 0, 0, 3'd0);
        last_vld_cyc = -1;
        cycle(0, 0, 4'd0, 16'h0, 0, 1, 3'd0);
        idle(1);
        chk("t4_wait_vld", br_vld, 1'b0);
        rc = cyc;
        cycle(0, 1, 4'd0, 16'h0005, 0, 0, 3'd0);
        for (int i = 0; i < 10 && last_vld_cyc < 0; i++) idle(1);
        chk("t4_lat", (last_vld_cyc < 0) ? 999 : last_vld_cyc - rc, BYP ? 1 : 2);
        chk("t4_taken", last_taken, 1'b1);

        // pending counter saturation and issue+retire cancel
        cycle(1, 0, 4'd0, 16'h1, 0, 0, 3'd0);
        cycle(1, 0, 4'd0, 16'h1, 0, 0, 3'd0);
        chk("t5_full", iss_rdy, 1'b0);
        cycle(1, 0, 4'd0, 16'h1, 0, 0, 3'd0);
        chk("t5_drop", iss_rdy, 1'b0);
        cycle(0, 1, 4'd0, 16'h1, 0, 0, 3'd0);
        cycle(1, 1, 4'd0, 16'h1, 0, 0, 3'd0);
        chk("t5_same", iss_rdy, 1'b1);
        cycle(1, 0, 4'd0, 16'h1, 0, 0, 3'd0);
        chk("t5_refill", iss_rdy, 1'b0);
        cycle(0, 1, 4'd0, 16'h1, 0, 0, 3'd0);
        cycle(0, 1, 4'd0, 16'h1, 0, 0, 3'd0);

        // Z-only and non-writing opcodes
        cycle(0, 1, 4'd1, 16'h8000, 1, 0, 3'd0);
        cycle(0, 1, 4'd2, 16'h0000, 0, 0, 3'd0);
        chk("t6_xor", flags, 3'b111);
        cycle(0, 1, 4'd3, 16'h0000, 0, 0, 3'd0);
        chk("t6_red", flags, 3'b111);

        // reset in the middle of WAIT
        cycle(1, 0, 4'd0, 16'h7, 0, 0, 3'd0);
        cycle(1, 0, 4'd0, 16'h7, 0, 0, 3'd0);
        cycle(0, 0, 4'd0, 16'h0, 0, 1, 3'd7);
        idle(1);
        async_reset_check();
        idle(4);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            iv  = ($urandom_range(0, 99) < 35);
            rv  = (m_pend > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 5);
            bq  = ($urandom_range(0, 99) < 30);
            res = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            cycle(iv, rv, 4'($urandom_range(0, 15)), res, 1'($urandom_range(0, 1)),
                  bq, 3'($urandom_range(0, 7)));
        end
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
